hd44780_text_buffer: RTL

//  Character store that feeds the HD44780 8-bit driver (hd447808b). It replaces the fixed
//  "A"+addr pattern with a ROWS x COLS RAM that a producer fills through a valid/ready port.
//  It answers the driver's idataaddr lookups combinationally and requests a screen refresh
//  (trg) whenever content changed. It runs on the same divided clock as the driver.

---
 rtl/hd44780_text_buffer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hd44780_text_buffer.sv
// Character RAM feeding the HD44780 8-bit driver: a producer fills it over valid/ready,
// the driver reads it by address, and a refresh request is raised whenever content changes.
module hd44780_text_buffer #(
  parameter int unsigned COLS        = 16,
  parameter int unsigned ROWS        = 2,
  parameter logic [7:0]  FILL        = 8'h20,
  parameter int unsigned TRG_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_char,
  input  logic       clr,
  input  logic       drv_busy,
  output logic       trg,
  input  logic [7:0] idataaddr,
  output logic [7:0] idata,
  output logic [7:0] cursor,
  output logic       dirty
);

  localparam int unsigned N  = ROWS * COLS;
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned TW = $clog2(TRG_TIMEOUT + 1);
  localparam logic [7:0]  LF = 8'h0A;
  localparam logic [7:0]  CR = 8'h0D;
  localparam logic [7:0]  BS = 8'h08;

  typedef enum logic {B_CLEAR, B_READY} bstate_t;
  typedef enum logic [1:0] {R_IDLE, R_WAITHI, R_WAITLO} rstate_t;

  bstate_t       bstate;
  rstate_t       rstate;
  logic [7:0]    clr_ptr;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]    mem [0:N-1];

  logic       xfer;
  logic       print_wr;
  logic       fire;
  logic       tmo_expire;
  logic [7:0] cursor_nx;

  assign wr_ready   = (bstate == B_READY) && !clr;
  assign xfer       = wr_valid && wr_ready;
  assign print_wr   = xfer && !(wr_char inside {LF, CR, BS});
  assign fire       = (rstate == R_IDLE) && dirty && !drv_busy && (bstate == B_READY) && !clr;
  assign tmo_expire = (rstate == R_WAITHI) && !drv_busy && (32'(tmo_cnt) == TRG_TIMEOUT - 1);

  // Cursor movement for an accepted character or control code
  always_comb begin
    int unsigned row;
    row       = 32'(cursor) / COLS;
    cursor_nx = cursor;
    if (xfer) begin
      case (wr_char)
        LF:      cursor_nx = (row + 1 >= ROWS) ? 8'd0 : 8'((row + 1) * COLS);
        CR:      cursor_nx = 8'(row * COLS);
        BS:      cursor_nx = (cursor == 8'd0) ? 8'd0 : cursor - 8'd1;
        default: cursor_nx = (32'(cursor) == N - 1) ? 8'd0 : cursor + 8'd1;
      endcase
    end
  end

  always_comb begin
    idata = FILL;
    if (bstate == B_READY && 32'(idataaddr) < N) idata = mem[idataaddr[AW-1:0]];
  end

  // Cell RAM is not reset; the clear sweep initialises it
  always_ff @(posedge clk) begin
    if (bstate == B_CLEAR)  mem[clr_ptr[AW-1:0]] <= FILL;
    else if (print_wr)      mem[cursor[AW-1:0]]  <= wr_char;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bstate  <= B_CLEAR;
      clr_ptr <= 8'd0;
      cursor  <= 8'd0;
    end else begin
      case (bstate)
        B_CLEAR: begin
          if (clr) begin
            clr_ptr <= 8'd0;
          end else if (32'(clr_ptr) == N - 1) begin
            clr_ptr <= 8'd0;
            bstate  <= B_READY;
          end else begin
            clr_ptr <= clr_ptr + 8'd1;
          end
        end
        B_READY: begin
          if (clr) begin
            bstate  <= B_CLEAR;
            clr_ptr <= 8'd0;
            cursor  <= 8'd0;
          end else begin
            cursor <= cursor_nx;
          end
        end
        default: bstate <= B_CLEAR;
      endcase
    end
  end

  // Refresh handshake; a change landing in the trigger cycle keeps dirty set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate  <= R_IDLE;
      trg     <= 1'b0;
      dirty   <= 1'b1;
      tmo_cnt <= '0;
    end else begin
      trg <= 1'b0;
      case (rstate)
        R_IDLE: begin
          if (fire) begin
            trg     <= 1'b1;
            rstate  <= R_WAITHI;
            tmo_cnt <= '0;
          end
        end
        R_WAITHI: begin
          if (drv_busy)        rstate  <= R_WAITLO;
          else if (tmo_expire) rstate  <= R_IDLE;
          else                 tmo_cnt <= tmo_cnt + TW'(1);
        end
        R_WAITLO: begin
          if (!drv_busy) rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
      if (fire) dirty <= 1'b0;
      if (tmo_expire || print_wr || clr) dirty <= 1'b1;
    end
  end

endmodule
